lsu_mem_ctrl: RTL and testbench

- Load/store initiator in the MEM stage. Sits between the pipeline and the word-only data memory, which has a combinational read and a synchronous word write.
- Converts LW/LH/LHU/LB/LBU/SW/SH/SB into word transactions and performs sign or zero extension on loads.
- SB/SH are implemented as a two-cycle read-modify-write. The controller stalls the pipeline while one is in progress.
- Misaligned accesses are detected and flagged; they never reach memory.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_mem_ctrl_if.sv | 36 +++
 rtl/lsu_lane_unit.sv | 62 ++++++
 rtl/lsu_mem_ctrl.sv | 149 ++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// =====================================================================
// Module   : lsu_pkg
// Summary  : Opcode, FSM state and width definitions for the load/store unit.
// Revision : 1.0 - initial release
// =====================================================================
package lsu_pkg;

    localparam int WORD_W = 32;
    localparam int OP_W   = 3;
    localparam int ST_W   = 2;

    localparam logic [OP_W-1:0] OP_LW  = 3'd0;
    localparam logic [OP_W-1:0] OP_LH  = 3'd1;
    localparam logic [OP_W-1:0] OP_LHU = 3'd2;
    localparam logic [OP_W-1:0] OP_LB  = 3'd3;
    localparam logic [OP_W-1:0] OP_LBU = 3'd4;
    localparam logic [OP_W-1:0] OP_SW  = 3'd5;
    localparam logic [OP_W-1:0] OP_SH  = 3'd6;
    localparam logic [OP_W-1:0] OP_SB  = 3'd7;

    localparam logic [ST_W-1:0] IDLE   = 2'd0;
    localparam logic [ST_W-1:0] RMW_WR = 2'd1;
    localparam logic [ST_W-1:0] RESP   = 2'd2;

    function automatic logic op_is_rmw(input logic [OP_W-1:0] op);
        return (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_ctrl_if.sv
`default_nettype none
// =====================================================================
// Module   : lsu_mem_ctrl_if
// Summary  : Pipeline request/response and data-memory signals of the LSU.
// Revision : 1.0 - initial release
// =====================================================================
interface lsu_mem_ctrl_if
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic [OP_W-1:0]   req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [WORD_W-1:0] req_pc;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] load_data;
    logic              misalign;
    logic [ADDR_W-1:0] dm_addr;
    logic [WORD_W-1:0] dm_wdata;
    logic              dm_we;
    logic [WORD_W-1:0] dm_rdata;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_pc, dm_rdata,
        input  busy, done, load_data, misalign, dm_addr, dm_wdata, dm_we
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_pc, dm_rdata,
        output busy, done, load_data, misalign, dm_addr, dm_wdata, dm_we
    );
endinterface
`default_nettype wire

// File: rtl/lsu_lane_unit.sv
`default_nettype none
// =====================================================================
// Module   : lsu_lane_unit
// Summary  : Combinational lane logic: load extract/extend, store merge, misalign detect.
// Revision : 1.0 - initial release
// =====================================================================
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [OP_W-1:0]   op_i,
    input  logic [1:0]        off_i,
    input  logic [WORD_W-1:0] rdata_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] load_o,
    output logic [WORD_W-1:0] merged_o,
    output logic              misalign_o
);
    logic [4:0]        w_byte_sh;
    logic [4:0]        w_half_sh;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [WORD_W-1:0] w_byte_mask;
    logic [WORD_W-1:0] w_half_mask;

    assign w_byte_sh   = {off_i, 3'b000};
    assign w_half_sh   = {off_i[1], 4'b0000};
    assign w_byte      = 8'(rdata_i >> w_byte_sh);
    assign w_half      = 16'(rdata_i >> w_half_sh);
    assign w_byte_mask = 32'h0000_00FF << w_byte_sh;
    assign w_half_mask = 32'h0000_FFFF << w_half_sh;

    always_comb begin
        load_o = '0;
        case (op_i)
            OP_LW:   load_o = rdata_i;
            OP_LH:   load_o = {{16{w_half[15]}}, w_half};
            OP_LHU:  load_o = {16'h0000, w_half};
            OP_LB:   load_o = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  load_o = {24'h00_0000, w_byte};
            default: load_o = '0;
        endcase
    end

    always_comb begin
        merged_o = wdata_i;
        case (op_i)
            OP_SB:   merged_o = (rdata_i & ~w_byte_mask) | ({24'h00_0000, wdata_i[7:0]} << w_byte_sh);
            OP_SH:   merged_o = (rdata_i & ~w_half_mask) | ({16'h0000, wdata_i[15:0]} << w_half_sh);
            default: merged_o = wdata_i;
        endcase
    end

    always_comb begin
        misalign_o = 1'b0;
        case (op_i)
            OP_LW, OP_SW:         misalign_o = |off_i;
            OP_LH, OP_LHU, OP_SH: misalign_o = off_i[0];
            default:              misalign_o = 1'b0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// =====================================================================
// Module   : lsu_mem_ctrl
// Summary  : MEM-stage load/store initiator for a word-only data memory; SB/SH via RMW.
//            Define LSU_TRACE_EN to print every memory write.
// Revision : 1.0 - initial release
// =====================================================================
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DM_WORDS = 1024
) (
    input  logic          clk,
    input  logic          reset,
    lsu_mem_ctrl_if.slave bus
);
    // Only the index bits the memory decodes are held across the RMW write cycle.
    localparam int IDX_W = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;

    logic [ST_W-1:0]   state_q, state_d;
    logic              done_q, done_d;
    logic              misalign_q, misalign_d;
    logic [WORD_W-1:0] load_data_q, load_data_d;
    logic [IDX_W-1:0]  rmw_idx_q, rmw_idx_d;
    logic [WORD_W-1:0] rmw_data_q, rmw_data_d;

    logic              w_accept;
    logic              w_is_load;
    logic              w_is_sw;
    logic              w_is_rmw;
    logic              w_misalign;
    logic [WORD_W-1:0] w_load_ext;
    logic [WORD_W-1:0] w_merged;

    assign w_accept  = bus.req_valid && (state_q != RMW_WR);
    assign w_is_load = (bus.req_op <= OP_LBU);
    assign w_is_sw   = (bus.req_op == OP_SW);
    assign w_is_rmw  = op_is_rmw(bus.req_op);

    lsu_lane_unit u_lane (
        .op_i       (bus.req_op),
        .off_i      (bus.req_addr[1:0]),
        .rdata_i    (bus.dm_rdata),
        .wdata_i    (bus.req_wdata),
        .load_o     (w_load_ext),
        .merged_o   (w_merged),
        .misalign_o (w_misalign)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (state_q != RMW_WR && w_accept) begin
            state_d = (w_is_rmw && !w_misalign) ? RMW_WR : RESP;
        end
    end

    always_comb begin
        bus.busy     = (state_q == RMW_WR);
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        done_d       = 1'b0;
        misalign_d   = 1'b0;
        load_data_d  = '0;
        rmw_idx_d    = rmw_idx_q;
        rmw_data_d   = rmw_data_q;
        if (state_q == RMW_WR) begin
            bus.dm_we    = 1'b1;
            bus.dm_addr  = ADDR_W'({rmw_idx_q, 2'b00});
            bus.dm_wdata = rmw_data_q;
            done_d       = 1'b1;
        end else if (w_accept) begin
            bus.dm_addr = {bus.req_addr[ADDR_W-1:2], 2'b00};
            done_d      = !w_is_rmw || w_misalign;
            misalign_d  = w_misalign;
            if (!w_misalign) begin
                if (w_is_load) begin
                    load_data_d = w_load_ext;
                end
                if (w_is_sw) begin
                    bus.dm_we    = 1'b1;
                    bus.dm_wdata = bus.req_wdata;
                end
                if (w_is_rmw) begin
                    rmw_idx_d  = bus.req_addr[IDX_W+1:2];
                    rmw_data_d = w_merged;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            load_data_q <= '0;
            rmw_idx_q   <= '0;
            rmw_data_q  <= '0;
        end else begin
            done_q      <= done_d;
            misalign_q  <= misalign_d;
            load_data_q <= load_data_d;
            rmw_idx_q   <= rmw_idx_d;
            rmw_data_q  <= rmw_data_d;
        end
    end

    assign bus.done      = done_q;
    assign bus.misalign  = misalign_q;
    assign bus.load_data = load_data_q;

`ifdef LSU_TRACE_EN
    logic [ADDR_W-1:0] trace_addr_q;
    logic [WORD_W-1:0] trace_pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trace_addr_q <= '0;
            trace_pc_q   <= '0;
        end else if (w_accept && w_is_rmw && !w_misalign) begin
            trace_addr_q <= bus.req_addr;
            trace_pc_q   <= bus.req_pc;
        end
    end

    always @(posedge clk) begin
        if (bus.dm_we) begin
            if (state_q == RMW_WR) begin
                $display("%0t@%h: *%h <= %h", $time, trace_pc_q, trace_addr_q, bus.dm_wdata);
            end else begin
                $display("%0t@%h: *%h <= %h", $time, bus.req_pc, bus.req_addr, bus.dm_wdata);
            end
        end
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^bus.req_pc;
`endif
endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// =====================================================================
// Module   : tb_lsu_mem_ctrl
// Summary  : Self-checking bench for lsu_mem_ctrl: directed steps plus random traffic vs a word-array model.
// Revision : 1.0 - initial release
// =====================================================================
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic mem_init;

    lsu_mem_ctrl_if #(.ADDR_W(32)) bus ();

    lsu_mem_ctrl #(.ADDR_W(32), .DM_WORDS(1024)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, synchronous word write, 10-bit word index.
    logic [31:0] mem [0:1023];
    assign bus.dm_rdata = mem[bus.dm_addr[11:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
        end else if (bus.dm_we) begin
            mem[bus.dm_addr[11:2]] <= bus.dm_wdata;
        end
    end

    // Transaction-level reference: memory image plus the response owed next cycle.
    logic [31:0] ref_mem [0:1023];
    logic        m_resp, m_mis, m_is_load, m_wr;
    logic [31:0] m_data, m_wr_addr, m_wr_word;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic bit misal(input logic [2:0] op, input logic [31:0] a);
        case (op)
            OP_LW, OP_SW:         return (a % 4) != 0;
            OP_LH, OP_LHU, OP_SH: return (a % 2) != 0;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ext(input logic [2:0] op, input logic [31:0] w, input int unsigned off);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (op)
            OP_LW:   return w;
            OP_LH:   return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            OP_LHU:  return h;
            OP_LB:   return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            OP_LBU:  return b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [2:0] op, input logic [31:0] w,
                                          input logic [31:0] d, input int unsigned off);
        if (op == OP_SB) begin
            return (w & ~(32'hFF << (8 * off))) | ((d & 32'hFF) << (8 * off));
        end
        return (w & ~(32'hFFFF << (16 * (off / 2)))) | ((d & 32'hFFFF) << (16 * (off / 2)));
    endfunction

    task automatic check_now();
        logic acc, exp_we;
        acc    = bus.req_valid && !m_wr;
        exp_we = m_wr || (acc && bus.req_op == OP_SW && !misal(bus.req_op, bus.req_addr));
        chk("busy", 32'(bus.busy), 32'(m_wr));
        chk("dm_we", 32'(bus.dm_we), 32'(exp_we));
        if (m_wr) begin
            chk("rmw_addr", bus.dm_addr, m_wr_addr);
            chk("rmw_wdata", bus.dm_wdata, m_wr_word);
        end else if (acc && !misal(bus.req_op, bus.req_addr)) begin
            chk("dm_addr", bus.dm_addr, bus.req_addr & 32'hFFFF_FFFC);
            if (exp_we) chk("sw_wdata", bus.dm_wdata, bus.req_wdata);
        end
        chk("done", 32'(bus.done), 32'(m_resp));
        chk("misalign", 32'(bus.misalign), 32'(m_resp & m_mis));
        if (m_resp && (m_is_load || m_mis)) chk("load_data", bus.load_data, m_data);
    endtask

    task automatic advance();
        int unsigned idx, off;
        idx       = 32'(bus.req_addr[11:2]);
        off       = 32'(bus.req_addr[1:0]);
        m_is_load = 1'b0;
        m_mis     = 1'b0;
        m_data    = 32'h0;
        if (m_wr) begin
            ref_mem[m_wr_addr[11:2]] = m_wr_word;
            m_wr   = 1'b0;
            m_resp = 1'b1;
        end else if (bus.req_valid) begin
            m_resp = 1'b1;
            m_mis  = misal(bus.req_op, bus.req_addr);
            if (!m_mis) begin
                if (bus.req_op <= OP_LBU) begin
                    m_is_load = 1'b1;
                    m_data    = ext(bus.req_op, ref_mem[idx], off);
                end else if (bus.req_op == OP_SW) begin
                    ref_mem[idx] = bus.req_wdata;
                end else begin
                    m_wr      = 1'b1;
                    m_resp    = 1'b0;
                    m_wr_addr = bus.req_addr & 32'hFFFF_FFFC;
                    m_wr_word = merge(bus.req_op, ref_mem[idx], bus.req_wdata, off);
                end
            end
        end else begin
            m_resp = 1'b0;
        end
    endtask

    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_pc    = $urandom;
        @(negedge clk);
        check_now();
        advance();
    endtask

    initial begin
        reset         = 1'b1;
        mem_init      = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_LW;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_pc    = 32'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        m_resp = 1'b0; m_mis = 1'b0; m_is_load = 1'b0; m_wr = 1'b0;
        m_data = 32'h0; m_wr_addr = 32'h0; m_wr_word = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_misalign", 32'(bus.misalign), 32'h0);
        chk("rst_load_data", bus.load_data, 32'h0);
        chk("rst_dm_we", 32'(bus.dm_we), 32'h0);
        chk("rst_dm_addr", bus.dm_addr, 32'h0);
        chk("rst_dm_wdata", bus.dm_wdata, 32'h0);
        mem_init = 1'b0;
        reset    = 1'b0;

        // Word store then load.
        step(1'b1, OP_SW, 32'h10, 32'h1234_5678);
        chk("sw_word_index", 32'(bus.dm_addr[11:2]), 32'd4);
        step(1'b1, OP_LW, 32'h10, 32'h0);
        step(1'b0, OP_LW, 32'h0, 32'h0);
        chk("lw_const", bus.load_data, 32'h1234_5678);

        // Byte loads with sign and zero extension.
        step(1'b1, OP_SW, 32'h20, 32'h80FF_7F01);
        step(1'b1, OP_LB, 32'h23, 32'h0);
        step(1'b1, OP_LBU, 32'h23, 32'h0);
        chk("lb23_const", bus.load_data, 32'hFFFF_FF80);
        step(1'b1, OP_LB, 32'h20, 32'h0);
        chk("lbu23_const", bus.load_data, 32'h0000_0080);
        step(1'b0, OP_LW, 32'h0, 32'h0);
        chk("lb20_const", bus.load_data, 32'h0000_0001);

        // Sub-word stores through read-modify-write.
        step(1'b1, OP_SW, 32'h30, 32'hAABB_CCDD);
        step(1'b1, OP_SB, 32'h31, 32'h0000_0011);
        step(1'b0, OP_LW, 32'h0, 32'h0);
        chk("sb_rmw_word", bus.dm_wdata, 32'hAABB_11DD);
        step(1'b1, OP_SH, 32'h32, 32'h0000_2233);
        chk("sb_done", 32'(bus.done), 32'h1);
        step(1'b0, OP_LW, 32'h0, 32'h0);
        chk("sh_rmw_word", bus.dm_wdata, 32'h2233_11DD);
        step(1'b1, OP_LW, 32'h30, 32'h0);
        step(1'b0, OP_LW, 32'h0, 32'h0);
        chk("rmw_readback", bus.load_data, 32'h2233_11DD);

        // Misaligned accesses are dropped.
        step(1'b1, OP_LW, 32'h02, 32'h0);
        step(1'b1, OP_SH, 32'h05, 32'h0000_BEEF);
        chk("mis_lw", 32'(bus.misalign), 32'h1);
        step(1'b0, OP_LW, 32'h0, 32'h0);
        chk("mis_sh", 32'(bus.misalign), 32'h1);
        chk("mis_mem0", mem[0], 32'h0);
        chk("mis_mem1", mem[1], 32'h0);

        // Reset arriving mid-way through the RMW write cycle.
        step(1'b1, OP_SW, 32'h40, 32'hCAFE_F00D);
        step(1'b1, OP_SB, 32'h40, 32'h0000_0055);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_now();
        #2 reset = 1'b1;
        #1;
        chk("rst_rmw_dm_we", 32'(bus.dm_we), 32'h0);
        chk("rst_rmw_busy", 32'(bus.busy), 32'h0);
        chk("rst_rmw_done", 32'(bus.done), 32'h0);
        m_wr = 1'b0; m_resp = 1'b0; m_mis = 1'b0; m_is_load = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        step(1'b0, OP_LW, 32'h0, 32'h0);
        chk("rst_rmw_mem", mem[16], 32'hCAFE_F00D);
        step(1'b1, OP_LW, 32'h40, 32'h0);
        step(1'b0, OP_LW, 32'h0, 32'h0);
        chk("rst_rmw_lw", bus.load_data, 32'hCAFE_F00D);

        // Back-to-back non-RMW traffic.
        step(1'b1, OP_LW, 32'h10, 32'h0);
        step(1'b1, OP_SW, 32'h50, 32'h5A5A_0F0F);
        step(1'b1, OP_LW, 32'h50, 32'h0);
        step(1'b0, OP_LW, 32'h0, 32'h0);
        chk("b2b_lw", bus.load_data, 32'h5A5A_0F0F);

        // Random traffic, including requests presented while busy.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 99) < 75), 3'($urandom_range(0, 7)),
                 32'($urandom_range(0, 255)), $urandom);
        end
        repeat (3) step(1'b0, OP_LW, 32'h0, 32'h0);
        for (int i = 0; i < 64; i++) chk("mem_image", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
